// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word, register index and writeback queue entry.
package cpu_types_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned WB_QDEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Long-latency result FIFO with per-entry live bits that can be squashed by destination register.
module wb_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = WB_QDEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  wb_entry_t                push_ent,
  input  logic                     pop,
  input  logic                     squash_en,
  input  regbits_t                 squash_wsel,
  output wb_entry_t                head,
  output logic                     head_live,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NREGS-1:0]         pend_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   live;
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head      = mem[rptr];
  assign head_live = live[rptr];

  // Payload storage needs no reset; only live bits decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= push_ent;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A push and a pop never target the same slot: pop needs non-empty, push needs non-full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PTR_W'(i) == wptr))
          live[i] <= !(squash_en && (push_ent.wsel == squash_wsel));
        else if ((pop && (PTR_W'(i) == rptr)) ||
                 (squash_en && (mem[i].wsel == squash_wsel)))
          live[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pend_mask[mem[i].wsel] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win, long-latency results drain from a queue.
module wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = WB_QDEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     pipe_wen,
  input  regbits_t                 pipe_wsel,
  input  word_t                    pipe_wdat,
  input  logic                     lu_valid,
  input  regbits_t                 lu_wsel,
  input  word_t                    lu_wdat,
  output logic                     lu_ready,
  output logic                     rf_wen,
  output regbits_t                 rf_wsel,
  output word_t                    rf_wdat,
  output logic [NREGS-1:0]         pend_mask,
  output logic [$clog2(DEPTH):0]   count
);

  logic      pipe_issue;
  logic      q_push;
  logic      q_pop;
  logic      q_empty;
  logic      q_full;
  logic      head_live;
  wb_entry_t head;
  wb_entry_t push_ent;
  logic      wen_d;
  regbits_t  wsel_d;
  word_t     wdat_d;

  assign push_ent = '{wsel: lu_wsel, wdat: lu_wdat};
  assign lu_ready = !q_full;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK         (CLK),
    .RST         (RST),
    .push        (q_push),
    .push_ent    (push_ent),
    .pop         (q_pop),
    .squash_en   (pipe_issue),
    .squash_wsel (pipe_wsel),
    .head        (head),
    .head_live   (head_live),
    .empty       (q_empty),
    .full        (q_full),
    .count       (count),
    .pend_mask   (pend_mask)
  );

  // r0 is hardwired zero, so writes to it never issue nor enqueue.
  always_comb begin
    pipe_issue = pipe_wen && (pipe_wsel != '0);
    q_push     = lu_valid && lu_ready && (lu_wsel != '0);
    q_pop      = !pipe_issue && !q_empty;
    wen_d      = 1'b0;
    wsel_d     = head.wsel;
    wdat_d     = head.wdat;
    if (pipe_issue) begin
      wen_d  = 1'b1;
      wsel_d = pipe_wsel;
      wdat_d = pipe_wdat;
    end else if (q_pop) begin
      wen_d  = head_live;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_wen  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else begin
      rf_wen <= wen_d;
      if (wen_d) begin
        rf_wsel <= wsel_d;
        rf_wdat <= wdat_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   pipe_wen = 1'b0;
  regbits_t               pipe_wsel = '0;
  word_t                  pipe_wdat = '0;
  logic                   lu_valid = 1'b0;
  regbits_t               lu_wsel = '0;
  word_t                  lu_wdat = '0;
  logic                   lu_ready;
  logic                   rf_wen;
  regbits_t               rf_wsel;
  word_t                  rf_wdat;
  logic [NREGS-1:0]       pend_mask;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  wb_entry_t prod_q[$];
  wb_entry_t wlog[$];

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
    .lu_valid(lu_valid), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat), .lu_ready(lu_ready),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .pend_mask(pend_mask), .count(count)
  );

  always #5 CLK = ~CLK;

  // Record every register-file write seen on the output port.
  always @(negedge CLK) begin
    if (!RST && rf_wen) wlog.push_back('{wsel: rf_wsel, wdat: rf_wdat});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive_lu();
    if (prod_q.size() > 0) begin
      lu_valid = 1'b1;
      lu_wsel  = prod_q[0].wsel;
      lu_wdat  = prod_q[0].wdat;
    end else begin
      lu_valid = 1'b0;
      lu_wsel  = '0;
      lu_wdat  = '0;
    end
  endtask

  task automatic set_pipe(input logic en, input regbits_t sel, input word_t dat);
    pipe_wen  = en;
    pipe_wsel = sel;
    pipe_wdat = dat;
  endtask

  // One clock: producer advances only on an accepted handshake.
  task automatic cycle();
    logic acc;
    acc = lu_valid && lu_ready;
    @(posedge CLK);
    #1;
    if (acc) void'(prod_q.pop_front());
    drive_lu();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0h exp=0", rf_wen); end
    total++; if (rf_wsel !== 5'd0) begin bad++; $display("FAIL rst_wsel got=%0h exp=0", rf_wsel); end
    total++; if (rf_wdat !== 32'd0) begin bad++; $display("FAIL rst_wdat got=%0h exp=0", rf_wdat); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (pend_mask !== 32'd0) begin bad++; $display("FAIL rst_pend got=%0h exp=0", pend_mask); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", lu_ready); end
    RST = 1'b0;
  endtask

  task automatic test_single_push();
    wlog.delete();
    prod_q.push_back('{wsel: 5'd5, wdat: 32'h0000_00AA});
    drive_lu();
    cycle();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL single_pend got=%0h exp=20", pend_mask); end
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen0 got=%0h exp=0", rf_wen); end
    cycle();
    total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%0h exp=1", rf_wen); end
    total++; if (rf_wsel !== 5'd5) begin bad++; $display("FAIL single_wsel got=%0d exp=5", rf_wsel); end
    total++; if (rf_wdat !== 32'hAA) begin bad++; $display("FAIL single_wdat got=%0h exp=aa", rf_wdat); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL single_pend_clr got=%0h exp=0", pend_mask); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
    cycle();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_idle_wen got=%0h exp=0", rf_wen); end
    total++; if (rf_wsel !== 5'd5) begin bad++; $display("FAIL single_hold_wsel got=%0d exp=5", rf_wsel); end
  endtask

  task automatic test_pipe_priority();
    int n;
    wlog.delete();
    for (int r = 7; r <= 11; r++) prod_q.push_back('{wsel: 5'(r), wdat: 32'h100 + 32'(r)});
    set_pipe(1'b1, 5'd3, 32'h11);
    drive_lu();
    for (int k = 0; k < 6; k++) begin
      cycle();
      n = (k + 1 < 4) ? k + 1 : 4;
      total++; if (count !== 3'(n)) begin bad++; $display("FAIL prio_count[%0d] got=%0d exp=%0d", k, count, n); end
      total++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd3) begin bad++; $display("FAIL prio_pipe[%0d] got=%0h/%0d exp=1/3", k, rf_wen, rf_wsel); end
      if (k >= 3) begin
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL prio_ready[%0d] got=%0h exp=0", k, lu_ready); end
      end
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    n = 0;
    while (n < 20 && !(count == 0 && prod_q.size() == 0)) begin cycle(); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL prio_drain_timeout got=%0d exp<20", n); end
    cycle();
    total++; if (wlog.size() != 11) begin bad++; $display("FAIL prio_nwrites got=%0d exp=11", wlog.size()); end
    for (int i = 0; i < 11 && i < wlog.size(); i++) begin
      regbits_t es;
      word_t    ed;
      es = (i < 6) ? 5'd3 : 5'(i + 1);
      ed = (i < 6) ? 32'h11 : 32'h100 + 32'(i + 1);
      total++;
      if (wlog[i].wsel !== es || wlog[i].wdat !== ed) begin
        bad++; $display("FAIL prio_order[%0d] got=%0d:%0h exp=%0d:%0h", i, wlog[i].wsel, wlog[i].wdat, es, ed);
      end
    end
  endtask

  task automatic test_squash();
    wlog.delete();
    prod_q.push_back('{wsel: 5'd4, wdat: 32'h44});
    set_pipe(1'b1, 5'd1, 32'h01);
    drive_lu();
    cycle();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL sq_count got=%0d exp=1", count); end
    total++; if (pend_mask !== 32'h10) begin bad++; $display("FAIL sq_pend got=%0h exp=10", pend_mask); end
    set_pipe(1'b1, 5'd4, 32'h99);
    cycle();
    total++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd4 || rf_wdat !== 32'h99) begin
      bad++; $display("FAIL sq_pipe got=%0h/%0d/%0h exp=1/4/99", rf_wen, rf_wsel, rf_wdat); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL sq_pend_clr got=%0h exp=0", pend_mask); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL sq_count_kept got=%0d exp=1", count); end
    set_pipe(1'b0, 5'd0, 32'h0);
    cycle();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL sq_pop_wen got=%0h exp=0", rf_wen); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL sq_pop_count got=%0d exp=0", count); end
    cycle();
    total++; if (wlog.size() != 2) begin bad++; $display("FAIL sq_nwrites got=%0d exp=2", wlog.size()); end
    if (wlog.size() > 0) begin
      total++;
      if (wlog[wlog.size()-1].wsel !== 5'd4 || wlog[wlog.size()-1].wdat !== 32'h99) begin
        bad++; $display("FAIL sq_final got=%0d:%0h exp=4:99", wlog[wlog.size()-1].wsel, wlog[wlog.size()-1].wdat);
      end
    end
  endtask

  task automatic test_r0();
    wlog.delete();
    prod_q.push_back('{wsel: 5'd0, wdat: 32'hDEAD});
    set_pipe(1'b1, 5'd0, 32'hBEEF);
    drive_lu();
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL r0_wen[%0d] got=%0h exp=0", k, rf_wen); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL r0_count[%0d] got=%0d exp=0", k, count); end
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    cycle();
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL r0_nwrites got=%0d exp=0", wlog.size()); end
  endtask

  task automatic test_reset_mid();
    for (int r = 12; r <= 14; r++) prod_q.push_back('{wsel: 5'(r), wdat: 32'(r)});
    set_pipe(1'b1, 5'd1, 32'h5);
    drive_lu();
    repeat (3) cycle();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rmid_fill got=%0d exp=3", count); end
    #2;
    RST = 1'b1;
    #1;
    wlog.delete();
    total++; if (rf_wen !== 1'b0 || rf_wsel !== 5'd0 || rf_wdat !== 32'd0) begin
      bad++; $display("FAIL rmid_rf got=%0h/%0d/%0h exp=0/0/0", rf_wen, rf_wsel, rf_wdat); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (pend_mask !== 32'd0) begin bad++; $display("FAIL rmid_pend got=%0h exp=0", pend_mask); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0h exp=1", lu_ready); end
    set_pipe(1'b0, 5'd0, 32'h0);
    prod_q.delete();
    drive_lu();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (6) cycle();
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL rmid_nwrites got=%0d exp=0", wlog.size()); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rmid_count_after got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    int n;
    int j;
    wlog.delete();
    for (int i = 0; i < 3 * DEPTH; i++) prod_q.push_back('{wsel: 5'(i + 1), wdat: 32'hC000_0000 + 32'(i)});
    set_pipe(1'b1, 5'd31, 32'h77);
    drive_lu();
    repeat (5) cycle();
    total++; if (count !== 3'(DEPTH)) begin bad++; $display("FAIL wrap_full got=%0d exp=%0d", count, DEPTH); end
    total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL wrap_ready got=%0h exp=0", lu_ready); end
    cycle();
    total++; if (count !== 3'(DEPTH)) begin bad++; $display("FAIL wrap_hold got=%0d exp=%0d", count, DEPTH); end
    set_pipe(1'b0, 5'd0, 32'h0);
    n = 0;
    while (n < 60 && !(count == 0 && prod_q.size() == 0)) begin
      cycle();
      n++;
      total++; if (count > 3'(DEPTH)) begin bad++; $display("FAIL wrap_ovf got=%0d exp<=%0d", count, DEPTH); end
    end
    total++; if (n >= 60) begin bad++; $display("FAIL wrap_drain_timeout got=%0d exp<60", n); end
    cycle();
    j = 0;
    foreach (wlog[i]) begin
      if (wlog[i].wsel != 5'd31) begin
        total++;
        if (wlog[i].wsel !== 5'(j + 1) || wlog[i].wdat !== 32'hC000_0000 + 32'(j)) begin
          bad++; $display("FAIL wrap_order[%0d] got=%0d:%0h exp=%0d:%0h", j, wlog[i].wsel, wlog[i].wdat, j + 1, 32'hC000_0000 + 32'(j));
        end
        j++;
      end
    end
    total++; if (j != 3 * DEPTH) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=%0d", j, 3 * DEPTH); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_pipe_priority();
    test_squash();
    test_r0();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
